// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: stage index constants,
// default stage count and stage index width.
package pipe_pkg;

    localparam int DEF_NUM_STAGES = 5;
    localparam int STAGE_W        = $clog2(DEF_NUM_STAGES);

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the optional pipeline performance counters.
// Holds at all-ones instead of wrapping; clr zeroes it synchronously.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled events, stop at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage valid bits, load enables, bubble clears and
// kill strobes for an N-stage in-order core (stage 0 = IF, N-1 = WB).
// Define PIPE_PERF_CNT_EN to add stall/flush/retire performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int HAZ_STAGE  = STG_ID,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_en,
    input  logic [NUM_STAGES-1:0]         busy,
    input  logic                          hazard_stall,
    input  logic [NUM_STAGES-1:0]         redirect_valid,
    output logic                          redirect_ready,
    output logic [$clog2(NUM_STAGES)-1:0] redirect_idx,
    output logic                          pc_en,
    output logic                          pc_redirect,
    output logic [NUM_STAGES-1:0]         stage_en,
    output logic [NUM_STAGES-1:0]         stage_clr,
    output logic [NUM_STAGES-1:0]         kill,
    output logic [NUM_STAGES-1:0]         valid
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt,
    output logic [CNT_W-1:0]              retire_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_STAGES);

    logic [NUM_STAGES-1:0] valid_r;
    logic [NUM_STAGES-1:0] busy_eff_s;
    logic [NUM_STAGES:0]   hold_raw_s;
    logic [NUM_STAGES-1:0] hold_s;
    logic [NUM_STAGES-1:0] kill_s;
    logic [NUM_STAGES-1:0] en_s;
    logic [NUM_STAGES-1:0] nvalid_s;
    logic [NUM_STAGES-1:0] clr_s;
    logic                  req_found_s;
    logic [IDX_W-1:0]      req_idx_s;
    logic                  accept_s;

    // Back-pressure chain from WB down to IF; an empty stage never holds
    always_comb begin
        hold_raw_s             = '0;
        hold_raw_s[NUM_STAGES] = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            hold_raw_s[i] = valid_r[i] & (busy_eff_s[i] | hold_raw_s[i+1]);
        end
    end

    // Pick the oldest (highest-index) valid stage requesting a redirect
    always_comb begin
        req_found_s = 1'b0;
        req_idx_s   = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            req_found_s = (redirect_valid[i] & valid_r[i]) ? 1'b1 : req_found_s;
            req_idx_s   = (redirect_valid[i] & valid_r[i]) ? IDX_W'(i) : req_idx_s;
        end
    end

    // A redirect is taken only if its own stage can advance this cycle
    always_comb begin
        accept_s = rst_n & req_found_s & ~hold_raw_s[req_idx_s];
    end

    genvar g;
    generate
        for (g = 0; g < NUM_STAGES; g++) begin : g_stage
            if (g == HAZ_STAGE) begin : g_haz
                assign busy_eff_s[g] = busy[g] | hazard_stall;
            end else begin : g_nohaz
                assign busy_eff_s[g] = busy[g];
            end

            // Younger stages behind an accepted redirect are flushed, never held
            assign kill_s[g] = accept_s & (IDX_W'(g) < req_idx_s);
            assign hold_s[g] = hold_raw_s[g] & ~kill_s[g];
            assign en_s[g]   = ~hold_s[g];

            if (g == 0) begin : g_if
                assign nvalid_s[g] = en_s[g] ? fetch_en : valid_r[g];
            end else begin : g_later
                assign nvalid_s[g] = hold_s[g] ? valid_r[g]
                                   : (valid_r[g-1] & ~hold_s[g-1] & ~kill_s[g-1]);
            end

            assign clr_s[g] = en_s[g] & ~nvalid_s[g];

            // Per-stage valid bit, cleared by reset
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_r[g] <= 1'b0;
                end else begin
                    valid_r[g] <= nvalid_s[g];
                end
            end
        end
    endgenerate

    // Combinational control outputs are quiet while reset is asserted
    always_comb begin
        stage_en       = {NUM_STAGES{rst_n}} & en_s;
        stage_clr      = {NUM_STAGES{rst_n}} & clr_s;
        kill           = {NUM_STAGES{rst_n}} & kill_s;
        redirect_ready = accept_s;
        redirect_idx   = rst_n ? req_idx_s : '0;
        pc_en          = rst_n & (en_s[0] | accept_s);
        pc_redirect    = accept_s;
        valid          = valid_r;
    end

`ifdef PIPE_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (rst_n & hold_s[0]),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (accept_s),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (rst_n & valid_r[NUM_STAGES-1] & ~hold_s[NUM_STAGES-1]),
        .count (retire_cnt)
    );
`endif

endmodule
